response_deserializer: RTL and testbench
========================================

RESPONSE_DESERIALIZER -- requirements
Module: response_deserializer

Interface
REQ-001 Parameter BITS, default 48, response frame length in bits including start and end bits.
REQ-002 Parameter BITS_COUNTER, default 6, bit counter width, SHALL be at least log2(BITS+1).
REQ-003 Parameter NCR_MAX, default 64, maximum clk cycles to wait for a start bit after arming.
REQ-004 clk  input  1  clock; cmd_in is sampled on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 arm  input  1  single-cycle pulse that starts waiting for a response; honoured only in IDLE.
REQ-007 crc_en  input  1  enables the CRC7 check; sampled on the cycle arm is accepted.
REQ-008 cmd_in  input  1  serial CMD line, idle high, MSB first.
REQ-009 response  output  BITS  captured frame, bit BITS-1 = start bit.
REQ-010 done  output  1  one-cycle pulse marking the end of a reception or a timeout.
REQ-011 crc_err  output  1  CRC7 mismatch, valid while done=1.
REQ-012 frame_err  output  1  start/transmission/end bit violation, valid while done=1.
REQ-013 timeout  output  1  no start bit within NCR_MAX cycles, valid while done=1.
REQ-014 busy  output  1  high in every state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_START, RECEIVE and DONE.
REQ-016 IDLE -> WAIT_START on arm=1; the wait counter clears and crc_en is latched.
REQ-017 WAIT_START: each cycle with cmd_in=1 increments the wait counter; reaching NCR_MAX -> DONE with timeout=1.
REQ-018 WAIT_START with cmd_in=0 -> RECEIVE; this sample is stored as bit BITS-1 and the bit counter becomes 1.
REQ-019 RECEIVE shifts one cmd_in sample per cycle into response, MSB first, and increments the bit counter.
REQ-020 After the BITS-th sample -> DONE.
REQ-021 CRC7 uses polynomial x^7+x^3+1 with initial value 0, computed serially over frame bits BITS-1..8 (start bit included), and is compared with bits 7..1.
REQ-022 crc_err = crc_en AND (computed CRC != received bits 7..1).
REQ-023 frame_err = (bit BITS-1 != 0) OR (bit BITS-2 != 0) OR (bit 0 != 1).
REQ-024 DONE lasts exactly one cycle: done=1 with flags valid, then -> IDLE.
REQ-025 Latency: done SHALL assert on the cycle after the last bit is sampled, BITS+1 cycles after the start-bit sample.
REQ-026 response SHALL hold its value from done until the next arm is accepted; arm clears response to 0.
REQ-027 On timeout, response SHALL read 0, crc_err=0 and frame_err=0.
REQ-028 arm asserted in WAIT_START, RECEIVE or DONE SHALL be ignored, with no restart.
REQ-029 arm in the same cycle as the DONE->IDLE transition SHALL be ignored; arm is accepted only when the state register is IDLE.
REQ-030 cmd_in SHALL be ignored in IDLE and DONE.
REQ-031 crc_err, frame_err and timeout SHALL be 0 whenever done=0.

Reset
REQ-032 reset=1 at a clk edge forces IDLE from any state, including mid-frame, and discards any partial frame.
REQ-033 Reset values: response=0, done=0, crc_err=0, frame_err=0, timeout=0, busy=0, all counters and the CRC register 0.
REQ-034 reset has priority over arm in the same cycle.

Verification
REQ-035 arm with crc_en=1, then cmd_in carries 0x000000000001 MSB first after 3 idle-high cycles -> done 49 cycles after the start bit; response=0x000000000001, crc_err=0, frame_err=0.
REQ-036 arm with crc_en=1, frame 0x400000000095 -> done; frame_err=1 (transmission bit set), crc_err=0 (CRC 0x4A matches).
REQ-037 arm, frame 0x000000000003 (bad CRC bit) -> crc_err=1; the same frame with crc_en=0 -> crc_err=0.
REQ-038 arm, cmd_in held high -> done with timeout=1 exactly NCR_MAX cycles after arm; response=0 and busy falls with done.
REQ-039 arm, then reset asserted after the 20th frame bit -> next cycle busy=0 and response=0; a fresh arm plus a valid frame completes normally.
REQ-040 arm pulsed again during RECEIVE and on the done cycle -> no restart; exactly one done; busy=0 afterwards.

Source files
------------

// File: rtl/response_deserializer.sv
// Serial response receiver: waits for a start bit on the CMD line, shifts in a
// fixed-length frame MSB first, then reports CRC7, framing and timeout status.
module response_deserializer #(
  parameter int BITS         = 48,
  parameter int BITS_COUNTER = 6,
  parameter int NCR_MAX      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arm,
  input  logic            crc_en,
  input  logic            cmd_in,
  output logic [BITS-1:0] response,
  output logic            done,
  output logic            crc_err,
  output logic            frame_err,
  output logic            timeout,
  output logic            busy
);

  localparam int WAIT_W = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [BITS-1:0]         r_resp;
  logic [BITS_COUNTER-1:0] r_bitcnt;
  logic [WAIT_W-1:0]       r_wait;
  logic [6:0]              r_crc;
  logic                    r_crc_en;
  logic                    r_timeout;
  logic                    w_wait_last;
  logic                    w_frame_full;
  logic                    w_crc_bit;

  // x^7 + x^3 + 1, one message bit per call
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign w_wait_last  = (r_wait == WAIT_W'(NCR_MAX - 1));
  assign w_frame_full = (r_bitcnt == BITS_COUNTER'(BITS));
  // Only bits BITS-1..8 feed the CRC; the last eight are CRC field and end bit.
  assign w_crc_bit    = (r_bitcnt < BITS_COUNTER'(BITS - 8));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (arm) w_next = WAIT_START;
      WAIT_START: begin
        if (!cmd_in)          w_next = RECEIVE;
        else if (w_wait_last) w_next = DONE;
      end
      RECEIVE:    if (w_frame_full) w_next = DONE;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_resp    <= '0;
      r_bitcnt  <= '0;
      r_wait    <= '0;
      r_crc     <= '0;
      r_crc_en  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_resp    <= '0;
            r_bitcnt  <= '0;
            r_wait    <= '0;
            r_crc     <= '0;
            r_crc_en  <= crc_en;
            r_timeout <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!cmd_in) begin
            r_resp   <= {r_resp[BITS-2:0], cmd_in};
            r_bitcnt <= BITS_COUNTER'(1);
            r_crc    <= crc7_step(r_crc, cmd_in);
          end else begin
            r_wait <= r_wait + 1'b1;
            if (w_wait_last) r_timeout <= 1'b1;
          end
        end
        RECEIVE: begin
          if (!w_frame_full) begin
            r_resp   <= {r_resp[BITS-2:0], cmd_in};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (w_crc_bit) r_crc <= crc7_step(r_crc, cmd_in);
          end
        end
        default: ;
      endcase
    end
  end

  assign response  = r_resp;
  assign done      = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign timeout   = done & r_timeout;
  // A timed-out reception has an all-zero response, so framing/CRC are masked.
  assign frame_err = done & ~r_timeout &
                     (r_resp[BITS-1] | r_resp[BITS-2] | ~r_resp[0]);
  assign crc_err   = done & ~r_timeout & r_crc_en & (r_crc != r_resp[7:1]);

endmodule

// File: tb/tb_response_deserializer.sv
// Scoreboard bench for response_deserializer: frames, CRC/framing errors,
// timeout, mid-frame reset and ignored re-arm pulses.
module tb_response_deserializer;
  localparam int BITS    = 48;
  localparam int NCR_MAX = 64;

  logic            clk = 1'b0;
  logic            reset, arm, crc_en, cmd_in;
  logic [BITS-1:0] response;
  logic            done, crc_err, frame_err, timeout, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [BITS-1:0] resp;
    logic            crc_err;
    logic            frame_err;
    logic            timeout;
  } exp_t;
  exp_t sb[$];

  response_deserializer #(.BITS(BITS), .BITS_COUNTER(6), .NCR_MAX(NCR_MAX)) dut (
    .clk(clk), .reset(reset), .arm(arm), .crc_en(crc_en), .cmd_in(cmd_in),
    .response(response), .done(done), .crc_err(crc_err), .frame_err(frame_err),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 by long division.
  function automatic logic [6:0] model_crc(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; crc_en = 1'b0; cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, crc_err, frame_err, timeout} !== 5'b0 || response !== '0) begin
      failures++;
      $display("FAIL reset_state got done=%b busy=%b crc=%b frm=%b to=%b resp=%h want all 0",
               done, busy, crc_err, frame_err, timeout, response);
    end
    arm = 1'b1;
    @(negedge clk);
    reset = 1'b0; arm = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_arm got busy=%b want 0", busy);
    end
  endtask

  task automatic run_frame(input logic [BITS-1:0] f, input logic en, input string name,
                           input bit pulse_arm);
    exp_t e;
    int   start_cyc, lat, dc0;
    bit   early, got;
    e.resp      = f;
    e.crc_err   = en && (model_crc(f[47:8]) != f[7:1]);
    e.frame_err = f[47] | f[46] | ~f[0];
    e.timeout   = 1'b0;
    sb.push_back(e);
    dc0 = done_cnt;
    arm = 1'b1; crc_en = en;
    @(negedge clk);
    arm = 1'b0; crc_en = ~en; cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    start_cyc = cyc;
    early = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      cmd_in = f[i];
      arm = (pulse_arm && i == 30);
      @(negedge clk);
      if (done) early = 1'b1;
    end
    arm = 1'b0; cmd_in = 1'b1; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (pulse_arm) arm = 1'b1;
    lat = cyc - start_cyc;
    e = sb.pop_front();
    checks++;
    if (!got || early) begin
      failures++;
      $display("FAIL %s_done got seen=%b early=%b want seen=1 early=0", name, got, early);
    end
    checks++;
    if (lat !== BITS + 1) begin
      failures++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, BITS + 1);
    end
    checks++;
    if (response !== e.resp || crc_err !== e.crc_err || frame_err !== e.frame_err ||
        timeout !== e.timeout || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_result got resp=%h crc=%b frm=%b to=%b busy=%b want resp=%h crc=%b frm=%b to=0 busy=1",
               name, response, crc_err, frame_err, timeout, busy,
               e.resp, e.crc_err, e.frame_err);
    end
    @(negedge clk);
    arm = 1'b0;
    cmd_in = pulse_arm ? 1'b0 : 1'b1;
    checks++;
    if ({done, busy, crc_err, frame_err, timeout} !== 5'b0 || response !== f) begin
      failures++;
      $display("FAIL %s_after got done=%b busy=%b flags=%b%b%b resp=%h want 0s resp=%h",
               name, done, busy, crc_err, frame_err, timeout, response, f);
    end
    if (pulse_arm) begin
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_no_restart got busy=%b want 0", name, busy);
      end
      cmd_in = 1'b1;
    end
    checks++;
    if (done_cnt - dc0 !== 1) begin
      failures++;
      $display("FAIL %s_done_count got %0d want 1", name, done_cnt - dc0);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   arm_cyc, lat;
    bit   got, busy_seen;
    e.resp = '0; e.crc_err = 1'b0; e.frame_err = 1'b0; e.timeout = 1'b1;
    sb.push_back(e);
    arm = 1'b1; crc_en = 1'b1; cmd_in = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    arm_cyc = cyc;
    busy_seen = busy;
    got = 1'b0;
    for (int k = 0; k < NCR_MAX + 8 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    lat = cyc - arm_cyc;
    e = sb.pop_front();
    checks++;
    if (!got || !busy_seen || lat !== NCR_MAX) begin
      failures++;
      $display("FAIL timeout_latency got seen=%b busy=%b lat=%0d want 1 1 %0d",
               got, busy_seen, lat, NCR_MAX);
    end
    checks++;
    if (response !== e.resp || timeout !== e.timeout || crc_err !== e.crc_err ||
        frame_err !== e.frame_err || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_result got resp=%h to=%b crc=%b frm=%b busy=%b want 0 1 0 0 1",
               response, timeout, crc_err, frame_err, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after got busy=%b done=%b to=%b want 0 0 0", busy, done, timeout);
    end
  endtask

  task automatic test_midframe_reset();
    logic [BITS-1:0] f;
    f = 48'h0000_0000_0001;
    arm = 1'b1; crc_en = 1'b1;
    @(negedge clk);
    arm = 1'b0; cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = BITS - 1; i >= BITS - 20; i--) begin
      cmd_in = (i == BITS - 3) ? 1'b1 : f[i];
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; cmd_in = 1'b1;
    checks++;
    if (busy !== 1'b0 || response !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset got busy=%b resp=%h done=%b want 0 0 0", busy, response, done);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; crc_en = 1'b0; cmd_in = 1'b1;
    @(negedge clk);
    test_reset();
    run_frame(48'h0000_0000_0001, 1'b1, "good",     1'b0);
    run_frame(48'h4000_0000_0095, 1'b1, "trans_bit", 1'b0);
    run_frame(48'h0000_0000_0003, 1'b1, "bad_crc",  1'b0);
    run_frame(48'h0000_0000_0003, 1'b0, "crc_off",  1'b0);
    run_frame(48'h0000_0000_0000, 1'b1, "end_bit",  1'b0);
    run_frame(48'h3A5C_1234_8001, 1'b1, "mixed",    1'b0);
    test_timeout();
    test_midframe_reset();
    run_frame(48'h0000_0000_0001, 1'b1, "post_reset", 1'b0);
    run_frame(48'h0000_0000_0001, 1'b1, "rearm",      1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
